pulse_peak_detector: RTL and testbench

//  Downstream stage of the vN_filter outputs: consumes one filter output stream, detects pulses above a

---
 rtl/pulse_peak_detector_pkg.sv | 27 ++
 rtl/pulse_peak_detector_event_fifo.sv | 52 +++++
 rtl/pulse_peak_detector.sv | 180 ++++++++++++++++++
 tb/tb_pulse_peak_detector.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_peak_detector_pkg.sv
// Shared types for the pulse peak detector: FSM state encoding, the default
// readout event layout and a counter-width helper.
package pulse_peak_detector_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int PD_TS_W          = 32;
    localparam int PD_WIDTH_W       = 8;

    // Readout word for a detector built with the default widths.
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [PD_TS_W-1:0]                 ts;
        logic [PD_WIDTH_W-1:0]              width;
    } pulse_event_t;

    typedef enum logic [1:0] {
        PD_IDLE  = 2'd0,
        PD_ARMED = 2'd1,
        PD_DEAD  = 2'd2
    } pd_state_t;

    // Bits needed to hold max_val, never less than one.
    function automatic int pd_counter_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_peak_detector_event_fifo.sv
// Synchronous event FIFO with first-word fall-through head output.
// A push on a full FIFO is accepted only when a pop frees a slot on the same edge.
module pulse_peak_detector_event_fifo #(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 4,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold pulse detector: tracks peak amplitude, peak timestamp and width of
// each pulse and queues one event per qualifying pulse toward readout.
module pulse_peak_detector
    import pulse_peak_detector_pkg::*;
#(
    parameter int DATA_W     = SIZE_FILTER_DATA,
    parameter int TS_W       = PD_TS_W,
    parameter int WIDTH_W    = PD_WIDTH_W,
    parameter int MIN_WIDTH  = 2,
    parameter int DEAD_TIME  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic signed [DATA_W-1:0] ev_amp,
    output logic [TS_W-1:0]          ev_ts,
    output logic [WIDTH_W-1:0]       ev_width,
    output logic [15:0]              lost_count,
    output logic                     busy
);

    localparam int EV_W   = DATA_W + TS_W + WIDTH_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DEAD_W = pd_counter_w(DEAD_TIME);

    typedef struct packed {
        logic signed [DATA_W-1:0] amp;
        logic [TS_W-1:0]          ts;
        logic [WIDTH_W-1:0]       width;
    } ev_t;

    function automatic logic [WIDTH_W-1:0] sat_inc_width(input logic [WIDTH_W-1:0] v);
        return (&v) ? v : v + WIDTH_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc_lost(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic [TS_W-1:0]          ts;
    logic signed [DATA_W-1:0] data_p0;
    logic [TS_W-1:0]          ts_p0;
    logic                     above_p0;

    pd_state_t                state;
    pd_state_t                state_nxt;
    logic                     load;
    logic                     extend;
    logic                     push;
    logic [DEAD_W-1:0]        dead_cnt;

    logic signed [DATA_W-1:0] peak_p1;
    logic [TS_W-1:0]          peak_ts_p1;
    logic [WIDTH_W-1:0]       width_p1;

    ev_t                      push_ev;
    ev_t                      head_ev;
    logic [EV_W-1:0]          head_word;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full;
    logic                     pop;
    logic                     drop;

    // Stage p0: register the sample with its timestamp and threshold compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            above_p0 <= 1'b0;
        end else begin
            ts       <= ts + TS_W'(1);
            above_p0 <= enable && (input_data > threshold);
        end
    end

    always_ff @(posedge clk) begin
        data_p0 <= input_data;
        ts_p0   <= ts;
    end

    // Stage p1: pulse tracking FSM, peak/width capture and event push
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        extend    = 1'b0;
        push      = 1'b0;
        if (!enable) begin
            state_nxt = PD_IDLE;
        end else begin
            case (state)
                PD_IDLE: begin
                    if (above_p0) begin
                        state_nxt = PD_ARMED;
                        load      = 1'b1;
                    end
                end
                PD_ARMED: begin
                    if (above_p0) begin
                        extend = 1'b1;
                    end else if (width_p1 >= WIDTH_W'(MIN_WIDTH)) begin
                        push      = 1'b1;
                        state_nxt = (DEAD_TIME == 0) ? PD_IDLE : PD_DEAD;
                    end else begin
                        state_nxt = PD_IDLE;
                    end
                end
                PD_DEAD: begin
                    if (dead_cnt <= DEAD_W'(1)) state_nxt = PD_IDLE;
                end
                default: state_nxt = PD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PD_IDLE;
            dead_cnt   <= '0;
            lost_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                dead_cnt <= DEAD_W'(DEAD_TIME);
            end else if (state == PD_DEAD && dead_cnt != '0) begin
                dead_cnt <= dead_cnt - DEAD_W'(1);
            end
            if (drop) lost_count <= sat_inc_lost(lost_count);
        end
    end

    // Strict greater-than keeps the first sample of a flat top as the peak.
    always_ff @(posedge clk) begin
        if (load) begin
            peak_p1    <= data_p0;
            peak_ts_p1 <= ts_p0;
            width_p1   <= WIDTH_W'(1);
        end else if (extend) begin
            width_p1 <= sat_inc_width(width_p1);
            if (data_p0 > peak_p1) begin
                peak_p1    <= data_p0;
                peak_ts_p1 <= ts_p0;
            end
        end
    end

    assign push_ev = '{amp: peak_p1, ts: peak_ts_p1, width: width_p1};

    // Stage p2: event queue toward readout
    pulse_peak_detector_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (pop),
        .head      (head_word),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_ev   = head_word;
    assign ev_valid  = ~fifo_empty;
    assign pop       = ev_valid & ev_ready;
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign drop      = push & fifo_full & ~pop;
    assign busy      = (state != PD_IDLE);

    // Fields read as zero while the queue is empty so nothing stale leaks out.
    assign ev_amp   = ev_valid ? head_ev.amp   : '0;
    assign ev_ts    = ev_valid ? head_ev.ts    : '0;
    assign ev_width = ev_valid ? head_ev.width : '0;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Self-checking bench for pulse_peak_detector: scenario tasks drive sample
// sequences and a scoreboard checks every event popped through the handshake.
module tb_pulse_peak_detector;

    localparam int DATA_W     = 16;
    localparam int TS_W       = 8;
    localparam int WIDTH_W    = 8;
    localparam int MIN_WIDTH  = 2;
    localparam int DEAD_TIME  = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic signed [DATA_W-1:0] amp;
        logic [TS_W-1:0]          ts;
        logic [WIDTH_W-1:0]       width;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic signed [DATA_W-1:0] input_data;
    logic signed [DATA_W-1:0] threshold;
    logic                     ev_valid;
    logic                     ev_ready;
    logic signed [DATA_W-1:0] ev_amp;
    logic [TS_W-1:0]          ev_ts;
    logic [WIDTH_W-1:0]       ev_width;
    logic [15:0]              lost_count;
    logic                     busy;

    exp_t            sb[$];
    int              seq[$];
    logic [TS_W-1:0] ts_log[$];
    logic [TS_W-1:0] ts_m;
    exp_t            mon_e;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              busy_cycles;

    pulse_peak_detector #(
        .DATA_W     (DATA_W),
        .TS_W       (TS_W),
        .WIDTH_W    (WIDTH_W),
        .MIN_WIDTH  (MIN_WIDTH),
        .DEAD_TIME  (DEAD_TIME),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .input_data (input_data),
        .threshold  (threshold),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_amp     (ev_amp),
        .ev_ts      (ev_ts),
        .ev_width   (ev_width),
        .lost_count (lost_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp: the stamp of a sample is the count
    // value while that sample is presented.
    always @(posedge clk or negedge reset) begin
        if (!reset) ts_m <= '0;
        else        ts_m <= ts_m + 1'b1;
    end

    // Scoreboard: the handshake seen at negedge is the pop of the next posedge.
    always @(negedge clk) begin
        if (reset === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got amp=%0d ts=%0d width=%0d, none expected",
                         ev_amp, ev_ts, ev_width);
            end else begin
                mon_e = sb.pop_front();
                if ({ev_amp, ev_ts, ev_width} !== {mon_e.amp, mon_e.ts, mon_e.width}) begin
                    n_fail++;
                    $display("FAIL event_fields: got amp=%0d ts=%0d width=%0d, expected amp=%0d ts=%0d width=%0d",
                             ev_amp, ev_ts, ev_width, mon_e.amp, mon_e.ts, mon_e.width);
                end
            end
        end
    end

    function automatic exp_t mk(input int amp, input logic [TS_W-1:0] ts, input int width);
        exp_t e;
        e.amp   = DATA_W'(amp);
        e.ts    = ts;
        e.width = WIDTH_W'(width);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic play();
        ts_log.delete();
        busy_cycles = 0;
        foreach (seq[i]) begin
            input_data = DATA_W'(seq[i]);
            ts_log.push_back(ts_m);
            step();
            if (busy) busy_cycles++;
        end
        seq.delete();
    endtask

    task automatic zeros(input int n);
        repeat (n) seq.push_back(0);
    endtask

    task automatic drain(output int left);
        int n = 0;
        ev_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        left = sb.size();
        sb.delete();
        ev_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; ev_ready = 1'b0;
        threshold = 16'sd100; input_data = '0;
        idle(3);
        n_checks++;
        if ({ev_valid, busy, lost_count, ev_amp, ev_ts, ev_width} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b busy=%0b lost=%0d amp=%0d ts=%0d width=%0d, expected all 0",
                     ev_valid, busy, lost_count, ev_amp, ev_ts, ev_width);
        end
        @(negedge clk) reset = 1'b1;
        idle(12);
        n_checks++;
        if ({ev_valid, busy, lost_count} !== '0) begin
            n_fail++;
            $display("FAIL after_reset_idle: valid=%0b busy=%0b lost=%0d, expected 0 0 0", ev_valid, busy, lost_count);
        end
    endtask

    task automatic test_basic_pulse();
        int left;
        threshold = 16'sd100;
        idle(12);
        seq = '{0, 150, 300, 200, 50};
        play();
        input_data = '0;
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_early: got %0b, expected 0 when closing sample just registered", ev_valid);
        end
        step();
        n_checks++;
        if (ev_valid !== 1'b1 || ev_amp !== 16'sd300 || ev_ts !== ts_log[2] || ev_width !== 8'd3) begin
            n_fail++;
            $display("FAIL basic_fwft: got valid=%0b amp=%0d ts=%0d width=%0d, expected 1 300 %0d 3",
                     ev_valid, ev_amp, ev_ts, ev_width, ts_log[2]);
        end
        sb.push_back(mk(300, ts_log[2], 3));
        drain(left);
        n_checks++;
        if (left != 0 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: %0d events unseen, valid=%0b, expected 0 and 0", left, ev_valid);
        end
    endtask

    task automatic test_short_pulse();
        idle(12);
        seq = '{0, 150, 0, 0, 0, 0, 0};
        play();
        n_checks++;
        if (busy_cycles != 1) begin
            n_fail++;
            $display("FAIL short_busy: got %0d busy cycles, expected 1", busy_cycles);
        end
        n_checks++;
        if (ev_valid !== 1'b0 || lost_count !== 16'd0) begin
            n_fail++;
            $display("FAIL short_no_event: got valid=%0b lost=%0d, expected 0 0", ev_valid, lost_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [TS_W-1:0] first_ts;
        int left;
        idle(12);
        first_ts = '0;
        for (int p = 0; p < 6; p++) begin
            seq = '{150, 250, 150};
            zeros(12);
            play();
            if (p == 0) first_ts = ts_log[1];
            if (p < FIFO_DEPTH) sb.push_back(mk(250, ts_log[1], 3));
            n_checks++;
            if (ev_valid !== 1'b1 || ev_amp !== 16'sd250 || ev_ts !== first_ts || ev_width !== 8'd3) begin
                n_fail++;
                $display("FAIL stall_hold p%0d: got valid=%0b amp=%0d ts=%0d width=%0d, expected 1 250 %0d 3",
                         p, ev_valid, ev_amp, ev_ts, ev_width, first_ts);
            end
        end
        n_checks++;
        if (lost_count !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_lost: got %0d, expected 2", lost_count);
        end
        drain(left);
        n_checks++;
        if (left != 0 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drain: %0d events unseen, valid=%0b, expected 0 and 0", left, ev_valid);
        end
    endtask

    task automatic test_plateau_dead();
        int left;
        idle(12);
        // close at index 4; 150s at close+3 fall in dead time, 180..190 at close+10 count
        seq = '{0, 200, 200, 200, 0, 0, 0, 150, 150, 150, 0, 0, 0, 0, 180, 190, 180};
        zeros(12);
        play();
        sb.push_back(mk(200, ts_log[1], 3));
        sb.push_back(mk(190, ts_log[15], 3));
        drain(left);
        n_checks++;
        if (left != 0 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL plateau_dead_drain: %0d events unseen, valid=%0b, expected 0 and 0", left, ev_valid);
        end
    endtask

    task automatic test_width_sat();
        int left;
        idle(12);
        seq.push_back(0);
        for (int i = 0; i < 300; i++) seq.push_back((i == 10) ? 500 : 120);
        zeros(12);
        play();
        sb.push_back(mk(500, ts_log[11], 255));
        drain(left);
        n_checks++;
        if (left != 0 || ev_valid !== 1'b0 || lost_count !== 16'd2) begin
            n_fail++;
            $display("FAIL width_sat: %0d events unseen, valid=%0b lost=%0d, expected 0 0 2",
                     left, ev_valid, lost_count);
        end
    endtask

    task automatic test_negative_thr();
        int left;
        input_data = -16'sd100;
        threshold  = -16'sd50;
        idle(12);
        seq = '{-100, -50, -30, -20, -100};
        repeat (12) seq.push_back(-100);
        play();
        sb.push_back(mk(-20, ts_log[3], 2));
        drain(left);
        n_checks++;
        if (left != 0 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL negative_thr: %0d events unseen, valid=%0b, expected 0 and 0", left, ev_valid);
        end
        threshold  = 16'sd100;
        input_data = '0;
    endtask

    task automatic test_reset_enable();
        idle(12);
        seq = '{150, 250, 150};
        zeros(12);
        seq.push_back(150); seq.push_back(250); seq.push_back(150);
        zeros(12);
        play();
        seq = '{150, 200};
        play();
        n_checks++;
        if (ev_valid !== 1'b1 || busy !== 1'b1 || lost_count !== 16'd2) begin
            n_fail++;
            $display("FAIL pre_reset_state: got valid=%0b busy=%0b lost=%0d, expected 1 1 2",
                     ev_valid, busy, lost_count);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({ev_valid, busy, lost_count, ev_amp} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0b busy=%0b lost=%0d amp=%0d, expected all 0",
                     ev_valid, busy, lost_count, ev_amp);
        end
        input_data = '0;
        @(negedge clk) reset = 1'b1;
        idle(12);
        seq = '{0, 150, 250};
        play();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_before_disable: got busy=%0b, expected 1", busy);
        end
        enable = 1'b0;
        seq = '{250, 250, 0, 0, 0};
        play();
        n_checks++;
        if (busy_cycles != 0) begin
            n_fail++;
            $display("FAIL disable_idle: got %0d busy cycles, expected 0", busy_cycles);
        end
        enable = 1'b1;
        zeros(12);
        play();
        n_checks++;
        if (ev_valid !== 1'b0 || busy_cycles != 0 || lost_count !== 16'd0) begin
            n_fail++;
            $display("FAIL disable_no_event: got valid=%0b busy_cycles=%0d lost=%0d, expected 0 0 0",
                     ev_valid, busy_cycles, lost_count);
        end
    endtask

    task automatic test_ts_wrap();
        int n = 0;
        int left;
        idle(12);
        while (ts_m != 8'd250 && n < 400) begin
            step();
            n++;
        end
        n_checks++;
        if (ts_m != 8'd250) begin
            n_fail++;
            $display("FAIL ts_wrap_wait: timestamp %0d after %0d cycles, expected 250", ts_m, n);
        end
        // samples stamped 250,251,...: the 210 peak lands on 257 mod 256 = 1
        seq = '{0, 150, 160, 170, 180, 190, 200, 210, 150};
        zeros(12);
        play();
        sb.push_back(mk(210, 8'd1, 8));
        drain(left);
        n_checks++;
        if (left != 0 || ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ts_wrap: %0d events unseen, valid=%0b, expected 0 and 0", left, ev_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pulse();
        test_short_pulse();
        test_back_to_back();
        test_plateau_dead();
        test_width_sat();
        test_negative_thr();
        test_reset_enable();
        test_ts_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
